// File: rtl/depth_test_writer.sv
// Depth-tested fragment sink: z-buffer read-modify-write pipeline plus full-frame clear.
// Build with DEPTH_TEST_EN defined to enable the z compare and the same-address hazard stall.
module depth_test_writer #(
    parameter int FB_HRES      = 320,
    parameter int FB_VRES      = 180,
    parameter int ZWIDTH       = 16,
    parameter int COLOR_WIDTH  = 16,
    parameter int BRAM_LATENCY = 2,
    parameter logic [COLOR_WIDTH-1:0] CLEAR_COLOR = '0,
    localparam int NPIX       = FB_HRES * FB_VRES,
    localparam int ADDR_WIDTH = $clog2(NPIX)
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   valid_in,
    output logic                   ready_out,
    input  logic [ADDR_WIDTH-1:0]  addr_in,
    input  logic [ZWIDTH-1:0]      z_in,
    input  logic [COLOR_WIDTH-1:0] color_in,
    input  logic                   last_pixel_in,
    input  logic                   clear_in,
    output logic [ADDR_WIDTH-1:0]  zb_raddr_out,
    input  logic [ZWIDTH-1:0]      zb_rdata_in,
    output logic                   zb_we_out,
    output logic [ADDR_WIDTH-1:0]  zb_waddr_out,
    output logic [ZWIDTH-1:0]      zb_wdata_out,
    output logic                   fb_we_out,
    output logic [ADDR_WIDTH-1:0]  fb_addr_out,
    output logic [COLOR_WIDTH-1:0] fb_data_out,
    output logic                   tri_done_out,
    output logic                   clear_done_out,
    output logic [ADDR_WIDTH:0]    drawn_count_out,
    output logic [1:0]             state_dbg_out
);
    localparam int L = BRAM_LATENCY;
    localparam logic [ADDR_WIDTH:0]   NPIX_W    = NPIX[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NPIX - 1);

    // Handshake: a fragment transfers in any cycle where valid_in && ready_out;
    // ready_out is a function of state and addr_in only, never of valid_in.
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_DRAIN = 2'd1, S_CLEAR = 2'd2} state_t;
    state_t state_q, state_d;

    logic                   live_q;
    logic [ADDR_WIDTH-1:0]  clr_cnt_q;
    logic                   clr_last_q;
    logic                   v_q    [0:L];
    logic [ADDR_WIDTH-1:0]  a_q    [0:L];
    logic [ZWIDTH-1:0]      z_q    [0:L-1];
    logic [COLOR_WIDTH-1:0] c_q    [0:L-1];
    logic                   last_q [0:L-1];

    logic                   we_q;
    logic [ADDR_WIDTH-1:0]  wr_addr_q;
    logic [ZWIDTH-1:0]      zdata_q;
    logic [COLOR_WIDTH-1:0] cdata_q;
    logic                   tri_q;
    logic                   cdone_q;
    logic [ADDR_WIDTH:0]    drawn_q;

    logic hazard, pipe_busy, pass, accept;

`ifndef DEPTH_TEST_EN
    logic unused_rdata;
    assign unused_rdata = ^zb_rdata_in;
`endif

    always_comb begin
        hazard    = 1'b0;
        pipe_busy = 1'b0;
        for (int i = 0; i <= L; i++) begin
            pipe_busy = pipe_busy | v_q[i];
`ifdef DEPTH_TEST_EN
            if (v_q[i] && (a_q[i] == addr_in)) hazard = 1'b1;
`endif
        end
        ready_out = live_q && (state_q == S_IDLE) && !hazard;
        accept    = valid_in && ready_out;
        // Stage L-1 is the fragment whose BRAM read data is arriving this cycle.
`ifdef DEPTH_TEST_EN
        zb_raddr_out = addr_in;
        pass = (z_q[L-1] < zb_rdata_in) && ({1'b0, a_q[L-1]} < NPIX_W);
`else
        zb_raddr_out = '0;
        pass = ({1'b0, a_q[L-1]} < NPIX_W);
`endif
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (clear_in) state_d = S_DRAIN;
            S_DRAIN: if (!pipe_busy) state_d = S_CLEAR;
            S_CLEAR: if (clr_cnt_q == LAST_ADDR) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= S_IDLE;
            live_q     <= 1'b0;
            clr_cnt_q  <= '0;
            clr_last_q <= 1'b0;
            for (int i = 0; i <= L; i++) begin
                v_q[i] <= 1'b0;
                a_q[i] <= '0;
            end
            for (int i = 0; i < L; i++) begin
                z_q[i]    <= '0;
                c_q[i]    <= '0;
                last_q[i] <= 1'b0;
            end
            we_q      <= 1'b0;
            wr_addr_q <= '0;
            zdata_q   <= '0;
            cdata_q   <= '0;
            tri_q     <= 1'b0;
            cdone_q   <= 1'b0;
            drawn_q   <= '0;
        end else begin
            state_q   <= state_d;
            live_q    <= 1'b0 | 1'b1;
            v_q[0]    <= accept;
            a_q[0]    <= addr_in;
            z_q[0]    <= z_in;
            c_q[0]    <= color_in;
            last_q[0] <= last_pixel_in;
            for (int i = 1; i <= L; i++) begin
                v_q[i] <= v_q[i-1];
                a_q[i] <= a_q[i-1];
            end
            for (int i = 1; i < L; i++) begin
                z_q[i]    <= z_q[i-1];
                c_q[i]    <= c_q[i-1];
                last_q[i] <= last_q[i-1];
            end

            we_q       <= 1'b0;
            tri_q      <= 1'b0;
            clr_last_q <= 1'b0;
            cdone_q    <= clr_last_q;

            if (state_q == S_CLEAR) begin
                we_q       <= 1'b1;
                wr_addr_q  <= clr_cnt_q;
                zdata_q    <= '1;
                cdata_q    <= CLEAR_COLOR;
                clr_last_q <= (clr_cnt_q == LAST_ADDR);
                clr_cnt_q  <= (clr_cnt_q == LAST_ADDR) ? '0 : clr_cnt_q + ADDR_WIDTH'(1);
            end else if (v_q[L-1]) begin
                we_q      <= pass;
                wr_addr_q <= a_q[L-1];
                zdata_q   <= z_q[L-1];
                cdata_q   <= c_q[L-1];
                tri_q     <= last_q[L-1];
                if (pass && (drawn_q != '1)) drawn_q <= drawn_q + (ADDR_WIDTH+1)'(1);
            end

            if ((state_q == S_DRAIN) && (state_d == S_CLEAR)) drawn_q <= '0;
        end
    end

    assign zb_we_out       = we_q;
    assign fb_we_out       = we_q;
    assign zb_waddr_out    = wr_addr_q;
    assign fb_addr_out     = wr_addr_q;
    assign zb_wdata_out    = zdata_q;
    assign fb_data_out     = cdata_q;
    assign tri_done_out    = tri_q;
    assign clear_done_out  = cdone_q;
    assign drawn_count_out = drawn_q;
    assign state_dbg_out   = state_q;
endmodule
